// File: rtl/alu_branch_addr_unit_pkg.sv
// Shared constants for the EX-stage datapath slice: datapath width and the
// 4-bit opcode space used by both the ALU and the branch comparator.
package alu_branch_addr_unit_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_SRA = 4'd8,
    OP_INC = 4'd9,
    OP_DEC = 4'd10,
    OP_MOV = 4'd11,
    OP_JMP = 4'd12,
    OP_BEQ = 4'd13,
    OP_BNE = 4'd14,
    OP_BLT = 4'd15
  } op_e;

  // Jump and branch codes occupy the top quarter of the opcode space.
  function automatic logic is_ctrl_op(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

endpackage

// File: rtl/alu_branch_addr_unit_if.sv
// Signal bundle between the pipeline registers and the EX datapath slice.
// master = pipeline side (drives operands), slave = the datapath slice.
interface alu_branch_addr_unit_if #(
  parameter int WIDTH = 16
);
  // EX-stage ALU
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_c;
  logic [WIDTH-1:0] alu_f;
  // ID-stage branch comparator
  logic [3:0]       cmp_op;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_taken;
  // data-memory address register
  logic             addr_ld;
  logic [WIDTH-1:0] addr_d;
  logic [WIDTH-1:0] addr_q;

  modport master (
    output alu_op, alu_a, alu_b, alu_c,
    output cmp_op, cmp_a, cmp_b,
    output addr_ld, addr_d,
    input  alu_f, cmp_taken, addr_q
  );

  modport slave (
    input  alu_op, alu_a, alu_b, alu_c,
    input  cmp_op, cmp_a, cmp_b,
    input  addr_ld, addr_d,
    output alu_f, cmp_taken, addr_q
  );
endinterface

// File: rtl/alu_branch_addr_unit_alu_core.sv
// Combinational ALU datapath. Modulo-2^WIDTH arithmetic, no flags.
// Shift amount comes from the low log2(WIDTH) bits of b only.
module alu_branch_addr_unit_alu_core
  import alu_branch_addr_unit_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] f
);

  localparam int SHW = $clog2(W);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  // Result mux; control-flow codes pass the jump/branch target through.
  always_comb begin
    f = c;
    case (op_e'(op))
      OP_ADD: f = a + b;
      OP_SUB: f = a - b;
      OP_AND: f = a & b;
      OP_OR:  f = a | b;
      OP_XOR: f = a ^ b;
      OP_NOT: f = ~a;
      OP_SLL: f = a << shamt;
      OP_SRL: f = a >> shamt;
      OP_SRA: f = W'($signed(a) >>> shamt);
      OP_INC: f = a + W'(1);
      OP_DEC: f = a - W'(1);
      OP_MOV: f = a;
      default: f = c;
    endcase
  end

endmodule

// File: rtl/alu_branch_addr_unit.sv
// EX-stage datapath slice: ALU (sub-module), ID-stage branch comparator and
// the data-memory address register. Comparator and ALU are purely
// combinational and ignore reset; only the address register is clocked.
module alu_branch_addr_unit
  import alu_branch_addr_unit_pkg::*;
(
  input  logic                  CLK,
  input  logic                  rst,
  alu_branch_addr_unit_if.slave bus
);

  logic [WIDTH-1:0] alu_f_w;

  alu_branch_addr_unit_alu_core #(.W(WIDTH)) u_alu_core (
    .op (bus.alu_op),
    .a  (bus.alu_a),
    .b  (bus.alu_b),
    .c  (bus.alu_c),
    .f  (alu_f_w)
  );

  assign bus.alu_f = alu_f_w;

  logic taken;

  // Branch decision settles in the same cycle: it feeds PC reload and flush.
  always_comb begin
    taken = 1'b0;
    if (is_ctrl_op(bus.cmp_op)) begin
      case (op_e'(bus.cmp_op))
        OP_JMP:  taken = 1'b1;
        OP_BEQ:  taken = (bus.cmp_a == bus.cmp_b);
        OP_BNE:  taken = (bus.cmp_a != bus.cmp_b);
        OP_BLT:  taken = ($signed(bus.cmp_a) < $signed(bus.cmp_b));
        default: taken = 1'b0;
      endcase
    end
  end

  assign bus.cmp_taken = taken;

  logic [WIDTH-1:0] addr_reg_d;
  logic [WIDTH-1:0] addr_reg_q;

  // Next address: load from the result bus when enabled, otherwise hold.
  always_comb begin
    addr_reg_d = addr_reg_q;
    if (bus.addr_ld) addr_reg_d = bus.addr_d;
  end

  // Address register; reset clears it immediately and wins over a load.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) addr_reg_q <= '0;
    else      addr_reg_q <= addr_reg_d;
  end

  assign bus.addr_q = addr_reg_q;

endmodule

// File: tb/tb_alu_branch_addr_unit.sv
// Bench for alu_branch_addr_unit: directed vector table, randomized checks
// against an arithmetic reference model, and address-register sequences.
module tb_alu_branch_addr_unit;
  import alu_branch_addr_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_branch_addr_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_branch_addr_unit dut (
    .CLK (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference ALU built from plain integer arithmetic.
  function automatic logic [15:0] ref_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [15:0] c);
    int ai = int'(a);
    int bi = int'(b);
    int sh = bi % 16;
    int r;
    case (op)
      4'd0:  r = ai + bi;
      4'd1:  r = ai - bi + 65536;
      4'd2:  r = int'(a & b);
      4'd3:  r = int'(a | b);
      4'd4:  r = int'(a ^ b);
      4'd5:  r = 65535 - ai;
      4'd6:  r = ai * (1 << sh);
      4'd7:  r = ai / (1 << sh);
      4'd8:  r = (ai >= 32768) ? 65535 - ((65535 - ai) / (1 << sh)) : ai / (1 << sh);
      4'd9:  r = ai + 1;
      4'd10: r = ai + 65535;
      4'd11: r = ai;
      default: r = int'(c);
    endcase
    r = r % 65536;
    return r[15:0];
  endfunction

  function automatic logic ref_t(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa = (int'(a) >= 32768) ? int'(a) - 65536 : int'(a);
    int sb = (int'(b) >= 32768) ? int'(b) - 65536 : int'(b);
    case (op)
      4'd12: return 1'b1;
      4'd13: return a == b;
      4'd14: return a != b;
      4'd15: return sa < sb;
      default: return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] f;
    logic        t;
  } vec_t;

  vec_t vecs[$];

  task automatic apply(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c);
    bus.alu_op = op; bus.alu_a = a; bus.alu_b = b; bus.alu_c = c;
    bus.cmp_op = op; bus.cmp_a = a; bus.cmp_b = b;
  endtask

  logic [15:0] model;

  initial begin
    rst = 1'b0;
    bus.addr_ld = 1'b1;
    bus.addr_d  = 16'h1111;
    apply(4'd0, 16'h0, 16'h0, 16'h0);

    // Directed table (applied while in reset: combinational paths ignore it)
    vecs.push_back('{4'd0,  16'hFFFF, 16'h0002, 16'h0000, 16'h0001, 1'b0});
    vecs.push_back('{4'd1,  16'h0003, 16'h0005, 16'h0000, 16'hFFFE, 1'b0});
    vecs.push_back('{4'd9,  16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{4'd6,  16'h8001, 16'h0011, 16'h0000, 16'h0002, 1'b0});
    vecs.push_back('{4'd7,  16'h8001, 16'h0001, 16'h0000, 16'h4000, 1'b0});
    vecs.push_back('{4'd8,  16'h8001, 16'h0001, 16'h0000, 16'hC000, 1'b0});
    vecs.push_back('{4'd2,  16'hF0F0, 16'h0FF0, 16'h0000, 16'h00F0, 1'b0});
    vecs.push_back('{4'd5,  16'h00FF, 16'h0000, 16'h0000, 16'hFF00, 1'b0});
    vecs.push_back('{4'd11, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 1'b0});
    vecs.push_back('{4'd12, 16'h0000, 16'h0000, 16'h0040, 16'h0040, 1'b1});
    vecs.push_back('{4'd13, 16'h0005, 16'h0005, 16'h1000, 16'h1000, 1'b1});
    vecs.push_back('{4'd13, 16'h0005, 16'h0006, 16'h2000, 16'h2000, 1'b0});
    vecs.push_back('{4'd14, 16'h0005, 16'h0006, 16'h0003, 16'h0003, 1'b1});
    vecs.push_back('{4'd15, 16'h8000, 16'h0001, 16'h0004, 16'h0004, 1'b1});
    vecs.push_back('{4'd15, 16'h0001, 16'h8000, 16'h0004, 16'h0004, 1'b0});
    vecs.push_back('{4'd4,  16'hAAAA, 16'hFFFF, 16'h0000, 16'h5555, 1'b0});
    vecs.push_back('{4'd10, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 1'b0});
    vecs.push_back('{4'd3,  16'h0F00, 16'h00F0, 16'h0000, 16'h0FF0, 1'b0});
    vecs.push_back('{4'd8,  16'h7FFF, 16'h000F, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{4'd8,  16'h8000, 16'h00FF, 16'h0000, 16'hFFFF, 1'b0});
    vecs.push_back('{4'd14, 16'h0007, 16'h0007, 16'h0009, 16'h0009, 1'b0});

    #1;
    chk16("reset_addr_q", bus.addr_q, 16'h0000);

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c);
      #1;
      chk16($sformatf("vec%0d_alu_f", i), bus.alu_f, vecs[i].f);
      chk1($sformatf("vec%0d_cmp_taken", i), bus.cmp_taken, vecs[i].t);
    end

    // Reset priority: load requested across edges while held in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk16("reset_beats_load", bus.addr_q, 16'h0000);

    // Release with load enabled: first edge after release loads
    rst = 1'b1;
    @(negedge clk);
    chk16("first_load_after_release", bus.addr_q, 16'h1111);

    bus.addr_d = 16'h00A5;
    @(negedge clk);
    chk16("load_a5", bus.addr_q, 16'h00A5);

    bus.addr_ld = 1'b0;
    bus.addr_d  = 16'hBEEF;
    @(negedge clk);
    chk16("hold_a5", bus.addr_q, 16'h00A5);

    // Async reset mid-cycle, checked well before the next rising edge
    rst = 1'b0;
    #1;
    chk16("async_reset_mid_cycle", bus.addr_q, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // Randomized ALU/comparator with independent operand sets
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  aop, cop;
      logic [15:0] a, b, c, ca, cb;
      aop = 4'($urandom_range(0, 15));
      cop = 4'($urandom_range(0, 15));
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
      ca = 16'($urandom); cb = 16'($urandom);
      if (n % 4 == 0) cb = ca;
      if (n % 8 == 1) begin ca[15] = 1'b1; cb[15] = 1'b0; end
      bus.alu_op = aop; bus.alu_a = a; bus.alu_b = b; bus.alu_c = c;
      bus.cmp_op = cop; bus.cmp_a = ca; bus.cmp_b = cb;
      #1;
      chk16($sformatf("rand%0d_alu_f op%0d", n, aop), bus.alu_f, ref_f(aop, a, b, c));
      chk1($sformatf("rand%0d_cmp op%0d", n, cop), bus.cmp_taken, ref_t(cop, ca, cb));
    end

    // Randomized address-register traffic with occasional resets
    model = bus.addr_q === 16'h0000 ? 16'h0000 : 16'hxxxx;
    @(negedge clk);
    model = 16'h0000;
    chk16("addr_after_sequence", bus.addr_q, model);
    for (int n = 0; n < 200; n++) begin
      logic       ld, r;
      logic [15:0] d;
      ld = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 15) != 0);
      d  = 16'($urandom);
      bus.addr_ld = ld;
      bus.addr_d  = d;
      rst = r;
      if (!r) begin
        model = 16'h0000;
        #1;
        chk16($sformatf("addr_rand%0d_async", n), bus.addr_q, 16'h0000);
      end else if (ld) begin
        model = d;
      end
      @(negedge clk);
      chk16($sformatf("addr_rand%0d", n), bus.addr_q, model);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
